ir_seq: RTL and testbench
=========================

IR_SEQ -- requirements
Module: ir_seq

Interface
REQ-001 Parameters SHALL be: PC_RST, 16'h0000, fetch address after reset; PC_STEP, 2, PC increment per fetched word.
REQ-002 Ports SHALL be, clock and reset first: CLK in 1 system clock (rising edge).
REQ-003 RST_N in 1; reset is asynchronous and active-low.
REQ-004 MEM_REQ out 1 instruction fetch request; MEM_ADDR out 16 fetch address; MEM_ACK in 1 fetch complete, data valid; MEM_DATA in 16 fetched word.
REQ-005 IR out 16 instruction register, consumed by the address generator.
REQ-006 REG, MOD, RAD out 1 each; addressing-class strobes to the address generator.
REQ-007 EXEC_DONE in 1 downstream execution finished; PC_LOAD in 1 branch taken; PC_IN in 16 branch target.
REQ-008 HALTED out 1 sequencer stopped on HALT opcode.

Function
REQ-009 FSM states SHALL be IDLE, FETCH, DECODE, STROBE, EXEC_WAIT, FLUSH, HALT.
REQ-010 IDLE: one cycle after reset release -> FETCH.
REQ-011 FETCH: MEM_REQ=1, MEM_ADDR=PC held stable until MEM_ACK sampled high; on ACK IR<=MEM_DATA, PC<=PC+PC_STEP (16-bit wrap, 16'hFFFE+2=16'h0000), -> DECODE.
REQ-012 DECODE: one cycle; class: IR[15:8]==8'hF4 -> HALT; IR[15:12]==4'b1011 -> REG; IR[15:12]==4'b1010 -> RAD; else IR[7:6]==2'b11 -> REG; else MOD.
REQ-013 STROBE: exactly one of REG/MOD/RAD high for exactly one cycle, registered, glitch-free; -> EXEC_WAIT.
REQ-014 REG/MOD/RAD SHALL be low in every other state, so each instruction yields a fresh rising edge.
REQ-015 IR SHALL stay constant from DECODE until the next IR load.
REQ-016 EXEC_WAIT: EXEC_DONE sampled only here; EXEC_DONE=1 with PC_LOAD=0 -> FETCH; with PC_LOAD=1 -> PC<=PC_IN, -> FETCH (or FLUSH, REQ-022).
REQ-017 PC_LOAD without EXEC_DONE SHALL be ignored.
REQ-018 HALT: HALTED=1, MEM_REQ=0, no strobes, exit only by reset.
REQ-019 Instruction latency without prefetch: strobe 2 cycles after the ACK cycle.

Reset
REQ-020 On RST_N low, asynchronously: state=IDLE, PC=PC_RST, MEM_ADDR=PC_RST, IR=16'h0000, MEM_REQ=0, REG=MOD=RAD=0, HALTED=0, prefetch buffer invalid; reset mid-handshake abandons the fetch, and a late MEM_ACK after release SHALL be ignored outside FETCH.

Configuration
REQ-021 Macro IR_SEQ_PREFETCH_EN: when defined, in EXEC_WAIT the block SHALL fetch PC into a one-word buffer (PF_BUF, PF_VALID), advancing PC on ACK; on EXEC_DONE with PF_VALID and no PC_LOAD, IR<=PF_BUF, -> DECODE directly, skipping FETCH.
REQ-022 With macro: EXEC_DONE and ACK in the same cycle SHALL load MEM_DATA into IR directly; PC_LOAD discards PF_VALID, and an outstanding request -> FLUSH, which holds MEM_REQ until ACK, discards data, then -> FETCH at PC_IN.
REQ-023 Without macro: no buffer, no FLUSH entry, MEM_REQ=0 in EXEC_WAIT; behaviour exactly REQ-016.

Structure
REQ-024 Shared package ir_seq_pkg SHALL hold the state enum, the class enum (CLS_REG, CLS_MOD, CLS_RAD, CLS_HALT), and opcode constants 4'b1011, 4'b1010, 8'hF4.
REQ-025 Classification SHALL be a combinational sub-module ir_class (IR in, class out); FSM, PC and prefetch buffer stay in ir_seq.

Verification
REQ-026 Reset, ACK after 3 wait cycles with 16'hB312 -> MEM_ADDR=16'h0000, IR=16'hB312, REG pulse 1 cycle, PC=16'h0002.
REQ-027 Words 16'h00C5, 16'h0045, 16'hA001 -> REG, MOD, RAD pulses in order, each 1 cycle, strobes low between.
REQ-028 PC_RST=16'hFFFE -> second fetch at MEM_ADDR=16'h0000.
REQ-029 EXEC_DONE+PC_LOAD, PC_IN=16'h0100 -> next MEM_ADDR=16'h0100; with IR_SEQ_PREFETCH_EN and outstanding prefetch -> FLUSH, stale word never reaches IR.
REQ-030 Word 16'hF400 -> HALTED=1, MEM_REQ=0 for 20 cycles; RST_N low mid-FETCH -> all outputs at reset values same cycle.
REQ-031 With IR_SEQ_PREFETCH_EN, ACK during EXEC_WAIT, EXEC_DONE later -> next strobe 2 cycles after EXEC_DONE, no FETCH cycle.

Source files
------------

// File: rtl/ir_seq_pkg.sv
// Shared types and opcode constants for the instruction sequencer.
// Consumed by ir_seq and ir_class.
package ir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    STROBE,
    EXEC_WAIT,
    FLUSH,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    CLS_REG,
    CLS_MOD,
    CLS_RAD,
    CLS_HALT
  } cls_t;

  localparam logic [3:0] OP_REG  = 4'b1011;
  localparam logic [3:0] OP_RAD  = 4'b1010;
  localparam logic [7:0] OP_HALT = 8'hF4;

  // {REG, MOD, RAD} one-hot for a class
  function automatic logic [2:0] cls_strobe(input cls_t c);
    logic [2:0] s;
    s = 3'b000;
    unique case (c)
      CLS_REG: s = 3'b100;
      CLS_MOD: s = 3'b010;
      CLS_RAD: s = 3'b001;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ir_class.sv
// Combinational addressing-class decoder for the instruction register.
// HALT and major-opcode matches take precedence over the mode field.
module ir_class
  import ir_seq_pkg::*;
(
  input  logic [15:0] ir,
  output cls_t        cls
);

  logic is_halt;
  logic is_reg;
  logic is_rad;
  logic is_mreg;

  assign is_halt = (ir[15:8] == OP_HALT);
  assign is_reg  = (ir[15:12] == OP_REG);
  assign is_rad  = (ir[15:12] == OP_RAD);
  assign is_mreg = !is_halt && !is_reg
                && !is_rad && (ir[7:6] == 2'b11);

  always_comb begin
    cls = CLS_MOD;
    unique case (1'b1)
      is_halt:         cls = CLS_HALT;
      is_reg, is_mreg: cls = CLS_REG;
      is_rad:          cls = CLS_RAD;
      default:         cls = CLS_MOD;
    endcase
  end

endmodule

// File: rtl/ir_seq.sv
// Instruction fetch/decode sequencer with registered class strobes.
// Define IR_SEQ_PREFETCH_EN to enable the one-word prefetch buffer.
module ir_seq
  import ir_seq_pkg::*;
#(
  parameter logic [15:0] PC_RST  = 16'h0000,
  parameter logic [15:0] PC_STEP = 16'd2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_DATA,
  output logic [15:0] IR,
  output logic        REG,
  output logic        MOD,
  output logic        RAD,
  input  logic        EXEC_DONE,
  input  logic        PC_LOAD,
  input  logic [15:0] PC_IN,
  output logic        HALTED
);

  state_t      state;
  logic [15:0] pc;
  cls_t        cls;

`ifdef IR_SEQ_PREFETCH_EN
  logic [15:0] pf_buf;
  logic        pf_valid;
`endif

  ir_class u_class (
    .ir  (IR),
    .cls (cls)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      pc       <= PC_RST;
      MEM_ADDR <= PC_RST;
      MEM_REQ  <= 1'b0;
      IR       <= 16'h0000;
      REG      <= 1'b0;
      MOD      <= 1'b0;
      RAD      <= 1'b0;
      HALTED   <= 1'b0;
`ifdef IR_SEQ_PREFETCH_EN
      pf_buf   <= 16'h0000;
      pf_valid <= 1'b0;
`endif
    end else begin
      // strobes live for the single STROBE cycle only
      {REG, MOD, RAD} <= 3'b000;
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          MEM_REQ  <= 1'b1;
          MEM_ADDR <= pc;
        end
        FETCH: begin
          if (MEM_ACK) begin
            IR      <= MEM_DATA;
            pc      <= pc + PC_STEP;
            MEM_REQ <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (cls == CLS_HALT) begin
            state  <= HALT;
            HALTED <= 1'b1;
          end else begin
            state           <= STROBE;
            {REG, MOD, RAD} <= cls_strobe(cls);
          end
        end
        STROBE: begin
          state <= EXEC_WAIT;
`ifdef IR_SEQ_PREFETCH_EN
          MEM_REQ  <= 1'b1;
          MEM_ADDR <= pc;
`endif
        end
        EXEC_WAIT: begin
`ifdef IR_SEQ_PREFETCH_EN
          if (EXEC_DONE) begin
            pf_valid <= 1'b0;
            if (PC_LOAD) begin
              pc <= PC_IN;
              if (MEM_REQ && !MEM_ACK) begin
                state <= FLUSH;
              end else begin
                state    <= FETCH;
                MEM_REQ  <= 1'b1;
                MEM_ADDR <= PC_IN;
              end
            end else if (pf_valid) begin
              IR    <= pf_buf;
              state <= DECODE;
            end else if (MEM_REQ && MEM_ACK) begin
              IR      <= MEM_DATA;
              pc      <= pc + PC_STEP;
              MEM_REQ <= 1'b0;
              state   <= DECODE;
            end else begin
              state    <= FETCH;
              MEM_REQ  <= 1'b1;
              MEM_ADDR <= pc;
            end
          end else if (MEM_REQ && MEM_ACK) begin
            pf_buf   <= MEM_DATA;
            pf_valid <= 1'b1;
            pc       <= pc + PC_STEP;
            MEM_REQ  <= 1'b0;
          end
`else
          if (EXEC_DONE) begin
            state   <= FETCH;
            MEM_REQ <= 1'b1;
            if (PC_LOAD) begin
              pc       <= PC_IN;
              MEM_ADDR <= PC_IN;
            end else begin
              MEM_ADDR <= pc;
            end
          end
`endif
        end
        FLUSH: begin
          // drain the stale request, then restart at the branch target
          if (MEM_ACK) begin
            state    <= FETCH;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= pc;
          end
        end
        HALT: begin
          MEM_REQ <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          MEM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_seq.sv
// Self-checking bench for ir_seq against a behavioural sequencer model.
// Covers both builds; prefetch steps run when IR_SEQ_PREFETCH_EN is defined.
module tb_ir_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        MEM_ACK;
  logic [15:0] MEM_DATA;
  logic        EXEC_DONE;
  logic        PC_LOAD;
  logic [15:0] PC_IN;

  logic        mem_req, reg_o, mod_o, rad_o, halted;
  logic [15:0] mem_addr, ir;
  logic        w_req, w_reg, w_mod, w_rad, w_halted;
  logic [15:0] w_addr, w_ir;

  int ncomp;
  int nfail;

  int pc_m;
  int pc2_m;
  logic [15:0] ir_m;

  ir_seq u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .MEM_REQ(mem_req), .MEM_ADDR(mem_addr),
    .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .IR(ir), .REG(reg_o), .MOD(mod_o), .RAD(rad_o),
    .EXEC_DONE(EXEC_DONE), .PC_LOAD(PC_LOAD),
    .PC_IN(PC_IN), .HALTED(halted)
  );

  ir_seq #(.PC_RST(16'hFFFE)) u_wrap (
    .CLK(CLK), .RST_N(RST_N),
    .MEM_REQ(w_req), .MEM_ADDR(w_addr),
    .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .IR(w_ir), .REG(w_reg), .MOD(w_mod), .RAD(w_rad),
    .EXEC_DONE(EXEC_DONE), .PC_LOAD(PC_LOAD),
    .PC_IN(PC_IN), .HALTED(w_halted)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int p);
    return (p + 2) % 65536;
  endfunction

  // {REG,MOD,RAD} expected for a word; zero means HALT
  function automatic logic [2:0] exp_stb(input logic [15:0] w);
    int v;
    v = int'(w);
    if (v / 256 == 'hF4) return 3'b000;
    if (v / 4096 == 11) return 3'b100;
    if (v / 4096 == 10) return 3'b001;
    if ((v / 64) % 4 == 3) return 3'b100;
    return 3'b010;
  endfunction

  function automatic logic [15:0] stb;
    return {13'd0, reg_o, mod_o, rad_o};
  endfunction

  task automatic model_reset;
    pc_m  = 0;
    pc2_m = 'hFFFE;
    ir_m  = 16'h0000;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {15'd0, mem_req}, 16'd0);
    chk({tag, "_addr"}, mem_addr, 16'h0000);
    chk({tag, "_ir"}, ir, 16'h0000);
    chk({tag, "_stb"}, stb(), 16'd0);
    chk({tag, "_halt"}, {15'd0, halted}, 16'd0);
    chk({tag, "_waddr"}, w_addr, 16'hFFFE);
  endtask

  task automatic fetch_one(input logic [15:0] w,
                           input int wt);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick;
      n++;
    end
    chk("req_seen", {15'd0, mem_req}, 16'd1);
    chk("addr", mem_addr, 16'(pc_m));
    chk("addr_wrap", w_addr, 16'(pc2_m));
    for (int i = 0; i < wt; i++) begin
      tick;
      chk("addr_hold", mem_addr, 16'(pc_m));
      chk("req_hold", {15'd0, mem_req}, 16'd1);
    end
    MEM_ACK  = 1'b1;
    MEM_DATA = w;
    tick;
    MEM_ACK  = 1'b0;
    MEM_DATA = 16'($urandom);
    pc_m  = nxt(pc_m);
    pc2_m = nxt(pc2_m);
    ir_m  = w;
    chk("ir_load", ir, w);
    chk("decode_quiet", stb(), 16'd0);
    tick;
    if (exp_stb(w) == 3'b000) begin
      chk("halted", {15'd0, halted}, 16'd1);
      chk("halt_req", {15'd0, mem_req}, 16'd0);
      chk("halt_stb", stb(), 16'd0);
    end else begin
      chk("strobe", stb(), {13'd0, exp_stb(w)});
      tick;
      chk("strobe_off", stb(), 16'd0);
      chk("ir_stable", ir, ir_m);
      chk("not_halted", {15'd0, halted}, 16'd0);
`ifndef IR_SEQ_PREFETCH_EN
      chk("exec_req", {15'd0, mem_req}, 16'd0);
`endif
    end
  endtask

  task automatic finish_exec(input bit ld,
                             input logic [15:0] tgt,
                             input int dly);
    for (int i = 0; i < dly; i++) begin
      PC_LOAD = 1'($urandom);
      PC_IN   = 16'($urandom);
      tick;
      chk("ir_hold", ir, ir_m);
    end
    EXEC_DONE = 1'b1;
    PC_LOAD   = ld;
    PC_IN     = tgt;
`ifdef IR_SEQ_PREFETCH_EN
    if (ld && mem_req) begin
      tick;
      EXEC_DONE = 1'b0;
      PC_LOAD   = 1'b0;
      chk("flush_req", {15'd0, mem_req}, 16'd1);
      MEM_ACK  = 1'b1;
      MEM_DATA = 16'hF400;
      tick;
      MEM_ACK = 1'b0;
      chk("flush_no_ir", ir, ir_m);
    end else begin
      tick;
    end
`else
    tick;
`endif
    EXEC_DONE = 1'b0;
    PC_LOAD   = 1'b0;
    if (ld) begin
      pc_m  = int'(tgt);
      pc2_m = int'(tgt);
    end
  endtask

  initial begin
    logic [15:0] w;
    ncomp = 0;
    nfail = 0;
    RST_N     = 1'b0;
    MEM_ACK   = 1'b0;
    MEM_DATA  = 16'h0000;
    EXEC_DONE = 1'b0;
    PC_LOAD   = 1'b0;
    PC_IN     = 16'h0000;
    model_reset;
    tick;
    tick;
    chk_reset("rst");

    RST_N = 1'b1;
    tick;
    chk("idle_to_fetch", {15'd0, mem_req}, 16'd1);

    fetch_one(16'hB312, 3);
    finish_exec(1'b0, 16'h0000, 2);
    fetch_one(16'h00C5, 0);
    finish_exec(1'b0, 16'h0000, 1);
    fetch_one(16'h0045, 1);
    finish_exec(1'b0, 16'h0000, 0);
    fetch_one(16'hA001, 2);
    finish_exec(1'b1, 16'h0100, 1);
    fetch_one(16'h1234, 0);
    finish_exec(1'b0, 16'h0000, 1);

`ifdef IR_SEQ_PREFETCH_EN
    fetch_one(16'h2222, 0);
    chk("pf_addr", mem_addr, 16'(pc_m));
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'hA0F0;
    tick;
    MEM_ACK = 1'b0;
    pc_m  = nxt(pc_m);
    pc2_m = nxt(pc2_m);
    chk("pf_req_drop", {15'd0, mem_req}, 16'd0);
    tick;
    tick;
    chk("pf_ir_keep", ir, 16'h2222);
    EXEC_DONE = 1'b1;
    tick;
    EXEC_DONE = 1'b0;
    ir_m = 16'hA0F0;
    chk("pf_ir_direct", ir, 16'hA0F0);
    chk("pf_no_fetch", {15'd0, mem_req}, 16'd0);
    tick;
    chk("pf_strobe", stb(), {13'd0, exp_stb(16'hA0F0)});
    tick;
    chk("pf_strobe_off", stb(), 16'd0);
    finish_exec(1'b1, 16'h0200, 1);
`endif

    for (int k = 0; k < 12; k++) begin
      w = 16'($urandom);
      if (w[15:8] == 8'hF4) w[8] = 1'b1;
      fetch_one(w, int'($urandom_range(0, 3)));
      finish_exec(1'($urandom),
                  16'($urandom) & 16'hFFFE,
                  int'($urandom_range(0, 3)));
    end

    fetch_one(16'hF400, 1);
    for (int i = 0; i < 20; i++) begin
      EXEC_DONE = 1'($urandom);
      MEM_ACK   = 1'($urandom);
      tick;
      chk("halt_hold", {14'd0, halted, mem_req}, 16'd2);
      chk("halt_quiet", stb(), 16'd0);
    end
    EXEC_DONE = 1'b0;
    MEM_ACK   = 1'b0;

    RST_N = 1'b0;
    tick;
    RST_N = 1'b1;
    model_reset;
    tick;
    tick;
    chk("refetch_req", {15'd0, mem_req}, 16'd1);
    RST_N = 1'b0;
    #1;
    chk_reset("async_rst");
    MEM_ACK  = 1'b1;
    MEM_DATA = 16'hB0C0;
    tick;
    RST_N = 1'b1;
    tick;
    MEM_ACK = 1'b0;
    chk("late_ack_ir", ir, 16'h0000);
    chk("late_ack_req", {15'd0, mem_req}, 16'd1);
    fetch_one(16'h0080, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule
